// File: rtl/access_key_sequencer.sv
// Access-sequence unlock engine: in-window reads whose key nibble matches a programmed sequence unlock
// a bounded run of LFSR-derived responses; unlocked and key_idx are registered, the response is combinational.
module access_key_sequencer #(
  parameter int                          WIN_W        = 2,
  parameter logic [WIN_W-1:0]            WIN_VAL      = 2'b01,
  parameter int                          KEY_W        = 4,
  parameter int                          KEY_LEN      = 4,
  parameter logic [KEY_LEN*KEY_W-1:0]    KEY_SEQ      = 16'h2A9C,
  parameter int                          RESP_W       = 2,
  parameter logic [5:0]                  LFSR_SEED    = 6'h2D,
  parameter int                          UNLOCK_READS = 8,
  parameter logic [KEY_W-1:0]            LOCK_SYM     = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sser_n,
  input  logic              br_w,
  input  logic [WIN_W-1:0]  ba_hi,
  input  logic [KEY_W-1:0]  ba_key,
  output logic [RESP_W-1:0] sd_out,
  output logic              sd_oe,
  output logic              unlocked,
  output logic [3:0]        key_idx
);

  if (LFSR_SEED == 6'h00) begin : g_bad_seed
    $error("access_key_sequencer: LFSR_SEED must be non-zero");
  end
  if (KEY_LEN < 1 || KEY_LEN > 16) begin : g_bad_len
    $error("access_key_sequencer: KEY_LEN must be 1..16");
  end
  if (UNLOCK_READS < 1 || UNLOCK_READS > 255) begin : g_bad_reads
    $error("access_key_sequencer: UNLOCK_READS must be 1..255");
  end
  if (RESP_W < 1 || RESP_W > 6) begin : g_bad_resp
    $error("access_key_sequencer: RESP_W must be 1..6");
  end

  typedef enum logic {HUNT, UNLOCKED} state_t;

  localparam logic [3:0] LAST_IDX = 4'(KEY_LEN - 1);
  localparam logic [7:0] CNT_INIT = 8'(UNLOCK_READS);

  state_t     state;
  logic [5:0] lfsr;
  logic [7:0] cnt;
  logic       acc;
  logic       par;

  // Unused table slots read as zero so key_idx can index the table at full width.
  logic [KEY_W-1:0] key_sym [16];
  for (genvar i = 0; i < 16; i++) begin : g_key
    if (i < KEY_LEN) begin : g_used
      assign key_sym[i] = KEY_SEQ[i*KEY_W +: KEY_W];
    end else begin : g_unused
      assign key_sym[i] = '0;
    end
  end

  assign acc    = !sser_n && br_w && (ba_hi == WIN_VAL);
  assign par    = ^lfsr;
  assign sd_oe  = acc && unlocked;
  assign sd_out = sd_oe ? (lfsr[RESP_W-1:0] ^ {RESP_W{par}}) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      unlocked <= 1'b0;
      key_idx  <= 4'd0;
      lfsr     <= LFSR_SEED;
      cnt      <= 8'd0;
    end else if (acc) begin
      case (state)
        HUNT: begin
          if (ba_key == key_sym[key_idx]) begin
            if (key_idx == LAST_IDX) begin
              state    <= UNLOCKED;
              unlocked <= 1'b1;
              key_idx  <= 4'd0;
              lfsr     <= LFSR_SEED;
              cnt      <= CNT_INIT;
            end else begin
              key_idx  <= key_idx + 4'd1;
            end
          end else begin
            // A broken sequence may itself be the start of a new attempt.
            key_idx <= (ba_key == key_sym[0]) ? 4'd1 : 4'd0;
          end
        end
        UNLOCKED: begin
          if (ba_key == LOCK_SYM) begin
            state    <= HUNT;
            unlocked <= 1'b0;
            key_idx  <= 4'd0;
          end else begin
            // x^6 + x^5 + 1, shifted left with feedback into bit 0.
            lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
            cnt  <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state    <= HUNT;
              unlocked <= 1'b0;
              key_idx  <= 4'd0;
            end
          end
        end
        default: begin
          state    <= HUNT;
          unlocked <= 1'b0;
          key_idx  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_access_key_sequencer.sv
// Directed-vector bench for access_key_sequencer with hand-computed LFSR responses
// (seed 2D gives sd_out 01,11,00,10,01,00,10,11 over the first eight reads).
module tb_access_key_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sser_n = 1'b1;
  logic       br_w = 1'b0;
  logic [1:0] ba_hi = 2'b00;
  logic [3:0] ba_key = 4'h0;
  logic [1:0] sd_out;
  logic       sd_oe;
  logic       unlocked;
  logic [3:0] key_idx;

  int checks = 0;
  int failures = 0;

  access_key_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sser_n   (sser_n),
    .br_w     (br_w),
    .ba_hi    (ba_hi),
    .ba_key   (ba_key),
    .sd_out   (sd_out),
    .sd_oe    (sd_oe),
    .unlocked (unlocked),
    .key_idx  (key_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       sser_n;
    logic       br_w;
    logic [1:0] ba_hi;
    logic [3:0] ba_key;
    logic       oe;   // expected sd_oe during the cycle
    logic [1:0] sd;   // expected sd_out during the cycle
    logic       unl;  // expected unlocked after the edge
    logic [3:0] idx;  // expected key_idx after the edge
  } vec_t;

  function automatic vec_t rd(logic [3:0] k, logic oe, logic [1:0] sd, logic unl, logic [3:0] idx);
    vec_t v;
    v.rst_n = 1'b1; v.sser_n = 1'b0; v.br_w = 1'b1; v.ba_hi = 2'b01; v.ba_key = k;
    v.oe = oe; v.sd = sd; v.unl = unl; v.idx = idx;
    return v;
  endfunction

  function automatic vec_t nv(logic s_n, logic bw, logic [1:0] hi, logic [3:0] k, logic unl, logic [3:0] idx);
    vec_t v;
    v.rst_n = 1'b1; v.sser_n = s_n; v.br_w = bw; v.ba_hi = hi; v.ba_key = k;
    v.oe = 1'b0; v.sd = 2'b00; v.unl = unl; v.idx = idx;
    return v;
  endfunction

  function automatic vec_t rst(vec_t v, logic oe, logic [1:0] sd);
    vec_t r;
    r = v;
    r.rst_n = 1'b0; r.oe = oe; r.sd = sd; r.unl = 1'b0; r.idx = 4'd0;
    return r;
  endfunction

  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag, input int step);
    @(negedge clk);
    rst_n = v.rst_n; sser_n = v.sser_n; br_w = v.br_w; ba_hi = v.ba_hi; ba_key = v.ba_key;
    #1;
    chk({tag, ".sd_oe"},  step, {7'd0, sd_oe},  {7'd0, v.oe});
    chk({tag, ".sd_out"}, step, {6'd0, sd_out}, {6'd0, v.sd});
    @(posedge clk);
    #1;
    chk({tag, ".unlocked"}, step, {7'd0, unlocked}, {7'd0, v.unl});
    chk({tag, ".key_idx"},  step, {4'd0, key_idx},  {4'd0, v.idx});
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = nv(1'b1, 1'b0, 2'b00, 4'h0, 1'b0, 4'd0);

    // reset
    tbl.push_back(rst(idle, 1'b0, 2'b00));
    // default key C,9,A,2
    tbl.push_back(rd(4'hC, 0, 2'b00, 0, 4'd1));
    tbl.push_back(rd(4'h9, 0, 2'b00, 0, 4'd2));
    tbl.push_back(rd(4'hA, 0, 2'b00, 0, 4'd3));
    tbl.push_back(rd(4'h2, 0, 2'b00, 1, 4'd0));
    // eight responses, relock after the eighth
    tbl.push_back(rd(4'h0, 1, 2'b01, 1, 4'd0));
    tbl.push_back(rd(4'h0, 1, 2'b11, 1, 4'd0));
    tbl.push_back(rd(4'h0, 1, 2'b00, 1, 4'd0));
    tbl.push_back(rd(4'h0, 1, 2'b10, 1, 4'd0));
    tbl.push_back(rd(4'h0, 1, 2'b01, 1, 4'd0));
    tbl.push_back(rd(4'h0, 1, 2'b00, 1, 4'd0));
    tbl.push_back(rd(4'h0, 1, 2'b10, 1, 4'd0));
    tbl.push_back(rd(4'h0, 1, 2'b11, 0, 4'd0));
    tbl.push_back(rd(4'h0, 0, 2'b00, 0, 4'd0));
    // overlap restart: C,9,C,9,A,2
    tbl.push_back(rd(4'hC, 0, 2'b00, 0, 4'd1));
    tbl.push_back(rd(4'h9, 0, 2'b00, 0, 4'd2));
    tbl.push_back(rd(4'hC, 0, 2'b00, 0, 4'd1));
    tbl.push_back(rd(4'h9, 0, 2'b00, 0, 4'd2));
    tbl.push_back(rd(4'hA, 0, 2'b00, 0, 4'd3));
    tbl.push_back(rd(4'h2, 0, 2'b00, 1, 4'd0));
    tbl.push_back(rd(4'hF, 1, 2'b01, 0, 4'd0));
    // non-accesses inside the key hold key_idx
    tbl.push_back(rd(4'hC, 0, 2'b00, 0, 4'd1));
    tbl.push_back(nv(1'b0, 1'b0, 2'b01, 4'h9, 0, 4'd1));
    tbl.push_back(rd(4'h9, 0, 2'b00, 0, 4'd2));
    tbl.push_back(nv(1'b1, 1'b1, 2'b01, 4'hA, 0, 4'd2));
    tbl.push_back(nv(1'b0, 1'b1, 2'b11, 4'h0, 0, 4'd2));
    tbl.push_back(rd(4'hA, 0, 2'b00, 0, 4'd3));
    tbl.push_back(nv(1'b0, 1'b0, 2'b01, 4'h5, 0, 4'd3));
    tbl.push_back(rd(4'h2, 0, 2'b00, 1, 4'd0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "tbl", i);

    // Lock symbol after three responses: that read is still answered with the pre-step value.
    apply(rd(4'h0, 1, 2'b01, 1, 4'd0), "lock", 0);
    apply(rd(4'h0, 1, 2'b11, 1, 4'd0), "lock", 1);
    apply(rd(4'h0, 1, 2'b00, 1, 4'd0), "lock", 2);
    apply(rd(4'hF, 1, 2'b10, 0, 4'd0), "lock", 3);
    apply(rd(4'h0, 0, 2'b00, 0, 4'd0), "lock", 4);

    // Reset mid-sequence: the remaining symbols alone must not unlock.
    apply(rd(4'hC, 0, 2'b00, 0, 4'd1), "rst_seq", 0);
    apply(rd(4'h9, 0, 2'b00, 0, 4'd2), "rst_seq", 1);
    apply(rst(rd(4'hA, 0, 2'b00, 0, 4'd0), 1'b0, 2'b00), "rst_seq", 2);
    apply(rd(4'hA, 0, 2'b00, 0, 4'd0), "rst_seq", 3);
    apply(rd(4'h2, 0, 2'b00, 0, 4'd0), "rst_seq", 4);

    // Reset while unlocked with five reads remaining, then a fresh unlock restarts from the seed.
    apply(rd(4'hC, 0, 2'b00, 0, 4'd1), "rst_unl", 0);
    apply(rd(4'h9, 0, 2'b00, 0, 4'd2), "rst_unl", 1);
    apply(rd(4'hA, 0, 2'b00, 0, 4'd3), "rst_unl", 2);
    apply(rd(4'h2, 0, 2'b00, 1, 4'd0), "rst_unl", 3);
    apply(rd(4'h0, 1, 2'b01, 1, 4'd0), "rst_unl", 4);
    apply(rd(4'h0, 1, 2'b11, 1, 4'd0), "rst_unl", 5);
    apply(rd(4'h0, 1, 2'b00, 1, 4'd0), "rst_unl", 6);
    apply(rst(rd(4'h0, 0, 2'b00, 0, 4'd0), 1'b1, 2'b10), "rst_unl", 7);
    apply(rd(4'h0, 0, 2'b00, 0, 4'd0), "rst_unl", 8);
    apply(rd(4'hC, 0, 2'b00, 0, 4'd1), "rst_unl", 9);
    apply(rd(4'h9, 0, 2'b00, 0, 4'd2), "rst_unl", 10);
    apply(rd(4'hA, 0, 2'b00, 0, 4'd3), "rst_unl", 11);
    apply(rd(4'h2, 0, 2'b00, 1, 4'd0), "rst_unl", 12);
    apply(rd(4'h0, 1, 2'b01, 1, 4'd0), "rst_unl", 13);
    apply(rd(4'h0, 1, 2'b11, 1, 4'd0), "rst_unl", 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/access_key_sequencer.md
Name: access_key_sequencer

Overview:
- Parametrised access-sequence unlock engine for the cartridge/security interface.
- Watches reads that hit a decoded address window and matches the low address nibble of each access against a programmed key sequence.
- When the full sequence is seen, it unlocks and returns an LFSR-derived response on the data lines for a bounded number of reads, then relocks.
- Successor to the fixed 6-bit GAL sequencer: key length, nibble width, response width, window decode and unlock lifetime are parameters, and it adds explicit lock and abort handling.

Parameters:
- WIN_W, 2: width of window-decode address field ba_hi.
- WIN_VAL, 2'b01: ba_hi value that selects the window (ba13=0, ba12=1).
- KEY_W, 4: width of key-symbol address field ba_key (BA7..BA4).
- KEY_LEN, 4: number of symbols in the unlock sequence, 1..16.
- KEY_SEQ, 16'h2A9C: packed key; symbol i is KEY_SEQ[i*KEY_W +: KEY_W], and symbol 0 is matched first.
- RESP_W, 2: number of response data bits.
- LFSR_SEED, 6'h2D: 6-bit LFSR value loaded on unlock; must be non-zero.
- UNLOCK_READS, 8: response reads allowed before automatic relock, 1..255.
- LOCK_SYM, 4'hF: key symbol that forces immediate relock while unlocked.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: synchronous active-low reset.
- sser_n, in, 1: interface select, active low.
- br_w, in, 1: 1 = read, 0 = write.
- ba_hi, in, WIN_W: window-decode address bits.
- ba_key, in, KEY_W: key-symbol address bits.
- sd_out, out, RESP_W: response data.
- sd_oe, out, 1: response-data drive enable; the pad tristate lives outside this block.
- unlocked, out, 1: sequencer is in UNLOCKED state.
- key_idx, out, 4: count of key symbols matched so far.

Behaviour:
- Definition: acc = !sser_n & br_w & (ba_hi == WIN_VAL). Evaluated combinationally; all state changes only on clk edges with acc = 1.
- Reset (rst_n = 0 at a clock edge): state = HUNT, key_idx = 0, LFSR = LFSR_SEED, read counter = 0, unlocked = 0, sd_oe = 0, sd_out = 0. Reset wins over every other event, including mid-sequence and mid-unlock.
- HUNT:
  - acc & ba_key == KEY_SEQ[key_idx]: key_idx + 1. If this completes the key (key_idx was KEY_LEN-1), go to UNLOCKED, load LFSR = LFSR_SEED, counter = UNLOCK_READS, key_idx = 0.
  - acc & mismatch: restart. key_idx = 1 if ba_key == KEY_SEQ[0], else 0 (the overlap case at symbol 0).
  - No acc: hold state. Writes and out-of-window reads neither advance nor abort the sequence.
- UNLOCKED:
  - acc & ba_key == LOCK_SYM: go to HUNT, key_idx = 0, no LFSR step.
  - acc, any other symbol: LFSR steps (taps x^6 + x^5 + 1, shift left, feedback into bit 0) and counter decrements. When the counter reaches 0 from 1, go to HUNT at that edge.
- Outputs:
  - unlocked is registered and equals (state == UNLOCKED).
  - sd_oe = acc & unlocked. It is combinational, giving zero-cycle drive for the current read.
  - sd_out = LFSR[RESP_W-1:0] XOR {RESP_W{parity(LFSR)}}. It is the pre-step value, so the read that triggers a step returns the old LFSR.
  - sd_out is 0 whenever sd_oe = 0.
- The final key-symbol read itself is not answered: unlocked rises after that edge, so sd_oe stays 0 during it.
- LFSR never reaches 0; seed 0 is a parameter error, checked by an elaboration assertion.
- key_idx saturates by construction (never exceeds KEY_LEN-1 in HUNT). It is zero-extended to 4 bits.

Test Plan:
1. Reset, then acc reads with ba_key = C,9,A,2 (default key). key_idx steps 1,2,3,0; unlocked = 1 after the 4th edge; sd_oe = 0 throughout.
2. Unlocked, 8 acc reads with ba_key = 0:
   - sd_oe = 1 on each read.
   - First sd_out is derived from LFSR 6'h2D: parity of 2D = 0, so sd_out = 2'b01.
   - Subsequent sd_out values match the reference LFSR model.
   - unlocked = 0 after the 8th edge.
3. Sequence C,9,C,9,A,2. The mismatch at the 3rd symbol re-matches symbol 0, so key_idx = 1. The sequence then completes and unlocks after the 6th read.
4. Interleave writes (br_w = 0), sser_n = 1 cycles and ba_hi = 2'b11 reads inside the key sequence. key_idx holds across them; unlock still occurs on the 4th valid read.
5. Unlocked, 3 response reads, then a read with ba_key = F. unlocked = 0 next edge; sd_oe stays 1 for that read; LFSR unchanged.
6. Assert rst_n = 0 at key_idx = 2, and again while unlocked with 5 reads remaining. Both return to the reset values on that edge; a fresh full key is required to unlock.
